// File: rtl/mf_mul_pipe.sv
// Pipelined integer multiplier for an out-of-order core's multiply unit.
// Operands are captured in stage 0 and multiplied into stage 1. The product
// is then carried down to the last stage, where the requested half is
// selected. A result held at the output with no grant stalls every stage.
// Flush drops all in-flight operations.
module mf_mul_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAGW  = 4,
    localparam int unsigned LAT  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAGW-1:0]  in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic             busy
);

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b11;

    // Stage valid bits, stage 0 at bit 0, output stage at bit LAT-1
    logic [LAT-1:0]     vld_q, vld_d;
    // Stage 0 operands
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    // Opcode is needed only until the half-select into the last stage
    logic [1:0]         op_q   [LAT-1];
    logic [1:0]         op_d   [LAT-1];
    logic [TAGW-1:0]    tag_q  [LAT];
    logic [TAGW-1:0]    tag_d  [LAT];
    // Full product, stages 1 .. LAT-2
    logic [2*WIDTH-1:0] prod_q [1:LAT-2];
    logic [2*WIDTH-1:0] prod_d [1:LAT-2];
    logic [WIDTH-1:0]   res_q, res_d;

    logic               stall;
    logic               accept;
    logic               sa, sb;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;

    assign out_valid  = vld_q[LAT-1];
    assign stall      = out_valid && !out_ready;
    assign in_ready   = !stall;
    assign accept     = in_valid && in_ready && !flush;
    assign busy       = |vld_q;
    assign out_result = res_q;
    assign out_tag    = tag_q[LAT-1];

    // Extend stage 0 operands to 2*WIDTH per opcode; the low 2*WIDTH bits
    // of the product of the extended values are the exact product.
    always_comb begin
        sa    = a_q[WIDTH-1] && (op_q[0] == OpMulh || op_q[0] == OpMulhsu);
        sb    = b_q[WIDTH-1] && (op_q[0] == OpMulh);
        a_ext = {{WIDTH{sa}}, a_q};
        b_ext = {{WIDTH{sb}}, b_q};
        prod  = a_ext * b_ext;
    end

    // Pipeline advance: flush clears valids, stall holds everything. Data
    // only moves behind a valid bit, so the output keeps its last value on
    // bubbles.
    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        tag_d  = tag_q;
        prod_d = prod_q;
        res_d  = res_q;
        if (flush) begin
            vld_d = '0;
        end else if (!stall) begin
            vld_d = {vld_q[LAT-2:0], accept};
            if (accept) begin
                a_d      = in_a;
                b_d      = in_b;
                op_d[0]  = in_op;
                tag_d[0] = in_tag;
            end
            if (vld_q[0]) begin
                prod_d[1] = prod;
                op_d[1]   = op_q[0];
                tag_d[1]  = tag_q[0];
            end
            for (int unsigned i = 2; i <= LAT - 2; i++) begin
                if (vld_q[i-1]) begin
                    prod_d[i] = prod_q[i-1];
                    op_d[i]   = op_q[i-1];
                    tag_d[i]  = tag_q[i-1];
                end
            end
            if (vld_q[LAT-2]) begin
                res_d = (op_q[LAT-2] == OpMul) ? prod_q[LAT-2][WIDTH-1:0]
                                               : prod_q[LAT-2][2*WIDTH-1:WIDTH];
                tag_d[LAT-1] = tag_q[LAT-2];
            end
        end
    end

    // State registers with asynchronous clear of valids and data
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '{default: '0};
            tag_q  <= '{default: '0};
            prod_q <= '{default: '0};
            res_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            tag_q  <= tag_d;
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

endmodule

// File: tb/tb_mf_mul_pipe.sv
// Scoreboard bench for mf_mul_pipe at WIDTH=32 and WIDTH=16. The stimulus
// thread pushes hand-computed results. Per-instance monitors pop and
// compare on each output handshake.
module tb_mf_mul_pipe;

    logic        clk;
    logic        RST;
    logic        flush;
    logic        out_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        iv   [2];
    logic        ov   [2];
    logic        ir   [2];
    logic        bs   [2];
    logic [31:0] ores [2];
    logic [3:0]  otag [2];
    logic [15:0] res16;

    int          n_tests;
    int          n_fail;
    logic        sel;
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];

    assign ores[1] = {16'h0, res16};

    mf_mul_pipe #(.WIDTH(32), .TAGW(4)) u_dut32 (
        .clk(clk), .RST(RST), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush), .out_valid(ov[0]),
        .out_ready(out_ready), .out_result(ores[0]), .out_tag(otag[0]), .busy(bs[0])
    );

    mf_mul_pipe #(.WIDTH(16), .TAGW(4)) u_dut16 (
        .clk(clk), .RST(RST), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(in_op),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_tag(in_tag), .flush(flush),
        .out_valid(ov[1]), .out_ready(out_ready), .out_result(res16), .out_tag(otag[1]),
        .busy(bs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (width %0d): got %0h, required %0h", name, sel ? 16 : 32, got,
                     exp);
        end
    endtask

    function automatic int qsize();
        return sel ? q1.size() : q0.size();
    endfunction

    // Output monitor: a handshake happens at the next posedge when both are high
    task automatic mon(input logic k);
        logic [35:0] e;
        if (!RST && ov[k] && out_ready) begin
            if ((k ? q1.size() : q0.size()) == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output (dut %0d): got tag %0h result %0h, required none",
                         k, otag[k], ores[k]);
            end else begin
                e = k ? q1.pop_front() : q0.pop_front();
                check("sb_tag", 64'(otag[k]), 64'(e[35:32]));
                check("sb_result", 64'(ores[k]), 64'(e[31:0]));
            end
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        mon(1'b0);
        mon(1'b1);
    end

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp, input bit push);
        int n;
        n      = 0;
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_tag = tag;
        iv[sel] = 1'b1;
        #1;
        while (!ir[sel] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ir[sel]) check("issue_ready_timeout", 64'(ir[sel]), 64'(1));
        if (push) begin
            if (sel) q1.push_back({tag, exp});
            else     q0.push_back({tag, exp});
        end
        @(posedge clk);
        @(negedge clk);
        iv[sel] = 1'b0;
    endtask

    task automatic measure_lat(input int exp_lat);
        int cnt;
        cnt = 1;
        #1;
        while (!ov[sel] && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        check("latency", 64'(cnt), 64'(exp_lat));
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        #1;
        while (!ov[sel] && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_out_valid", 64'(ov[sel]), 64'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (qsize() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(qsize()), 64'(0));
    endtask

    task automatic count_run();
        int n;
        int cnt;
        n   = 0;
        cnt = 0;
        #1;
        while (!ov[sel] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        while (ov[sel] && cnt < 20) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("b2b_run_length", 64'(cnt), 64'(8));
    endtask

    task automatic run_suite();
        logic [31:0] ones, mn, hu, q;
        int          lat;
        ones = sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        mn   = sel ? 32'h0000_8000 : 32'h8000_0000;
        hu   = sel ? 32'h0000_FFFE : 32'hFFFF_FFFE;
        q    = sel ? 32'h0000_4000 : 32'h4000_0000;
        lat  = sel ? 5 : 6;
        out_ready = 1'b1;

        // Basic MUL and latency
        issue(2'b00, 32'd7, 32'd6, 4'd3, 32'd42, 1'b1);
        measure_lat(lat);
        drain();

        // High-half modes and sign handling
        issue(2'b01, ones, ones, 4'd1, 32'd0, 1'b1);
        issue(2'b10, ones, ones, 4'd2, hu, 1'b1);
        issue(2'b11, ones, 32'd2, 4'd4, ones, 1'b1);
        issue(2'b00, ones, ones, 4'd5, 32'd1, 1'b1);
        issue(2'b01, mn, mn, 4'd6, q, 1'b1);
        issue(2'b11, 32'd2, ones, 4'd7, 32'd1, 1'b1);
        issue(2'b01, hu, 32'd3, 4'd8, ones, 1'b1);
        drain();

        // Eight back-to-back operations
        fork
            for (int i = 0; i < 8; i++) issue(2'b00, 32'(i), 32'd3, 4'(i), 32'(i * 3), 1'b1);
            count_run();
        join
        drain();

        // Three-cycle stall at the output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(2'b00, 32'(i + 1), 32'd10, 4'(8 + i), 32'((i + 1) * 10), 1'b1);
        wait_ov();
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", 64'(ir[sel]), 64'(0));
            check("stall_result", 64'(ores[sel]), 64'(10));
            check("stall_tag", 64'(otag[sel]), 64'(8));
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Flush with four in flight and a new offer in the same cycle
        for (int i = 0; i < 4; i++) issue(2'b00, 32'(i), 32'd2, 4'(i), 32'd0, 1'b0);
        in_op   = 2'b00;
        in_a    = 32'd9;
        in_b    = 32'd9;
        in_tag  = 4'd15;
        iv[sel] = 1'b1;
        flush   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[sel] = 1'b0;
        flush   = 1'b0;
        #1;
        check("flush_out_valid", 64'(ov[sel]), 64'(0));
        check("flush_busy", 64'(bs[sel]), 64'(0));
        repeat (lat + 4) @(negedge clk);
        check("post_flush_busy", 64'(bs[sel]), 64'(0));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) issue(2'b00, 32'(i + 1), 32'd7, 4'(i), 32'd0, 1'b0);
        #3;
        RST = 1'b1;
        #1;
        check("rst_out_valid", 64'(ov[sel]), 64'(0));
        check("rst_busy", 64'(bs[sel]), 64'(0));
        check("rst_out_result", 64'(ores[sel]), 64'(0));
        check("rst_out_tag", 64'(otag[sel]), 64'(0));
        check("rst_in_ready", 64'(ir[sel]), 64'(1));
        @(negedge clk);
        RST = 1'b0;
        issue(2'b00, 32'd5, 32'd5, 4'd9, 32'd25, 1'b1);
        measure_lat(lat);
        drain();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        sel       = 1'b0;
        RST       = 1'b1;
        iv[0]     = 1'b0;
        iv[1]     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            check("reset_out_valid", 64'(ov[sel]), 64'(0));
            check("reset_busy", 64'(bs[sel]), 64'(0));
            check("reset_in_ready", 64'(ir[sel]), 64'(1));
            check("reset_out_result", 64'(ores[sel]), 64'(0));
            check("reset_out_tag", 64'(otag[sel]), 64'(0));
        end
        @(negedge clk);
        RST = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            run_suite();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mf_mul_pipe.md
MF_MUL_PIPE -- requirements
Module: mf_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, 32, operand width; a power of two, 8..64.
REQ-002 SHALL have parameter TAGW, 4, width of the reservation-station tag carried with each operation.
REQ-003 SHALL have parameter LAT, derived as log2(WIDTH)+1, fixed accept-to-out_valid latency in cycles (6 at WIDTH=32).
REQ-004 SHALL have one clock and asynchronous, active-high reset, exactly as follows:
- clk  in  1  clock; all state on rising edge
- RST  in  1  asynchronous active-high reset
REQ-005 SHALL have these remaining ports:
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  2  00 MUL low, 01 MULH signed×signed high, 10 MULHU unsigned×unsigned high, 11 MULHSU signed×unsigned high
- in_a  in  WIDTH  operand 1 (signed in MULHSU)
- in_b  in  WIDTH  operand 2
- in_tag  in  TAGW  destination tag
- flush  in  1  discard all in-flight operations
- out_valid  out  1  result available
- out_ready  in  1  CDB grant; result consumed
- out_result  out  WIDTH  selected product half
- out_tag  out  TAGW  tag of out_result
- busy  out  1  any pipeline stage occupied

Function
REQ-006 SHALL be fully pipelined: one operation accepted per cycle while not stalled.
REQ-007 SHALL accept an operation on a rising edge where in_valid && in_ready && !flush.
REQ-008 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-009 SHALL, when out_valid && !out_ready, freeze every stage, including valid bits, tags and partial sums (global stall); nothing is lost or duplicated.
REQ-010 SHALL, when not stalled, advance every stage by one each cycle; a bubble enters when nothing is accepted.
REQ-011 SHALL raise out_valid exactly LAT cycles after acceptance when no stall intervenes; each stall cycle adds one cycle.
REQ-012 SHALL compute the full 2*WIDTH-bit product, with each operand sign- or zero-extended per in_op.
REQ-013 SHALL output bits [WIDTH-1:0] for MUL (identical for signed and unsigned) and bits [2*WIDTH-1:WIDTH] for MULH, MULHU and MULHSU.
REQ-014 SHALL carry in_op and in_tag alongside the data, so that out_tag matches the tag of the operation producing out_result.
REQ-015 SHALL hold out_result and out_tag stable while out_valid && !out_ready.
REQ-016 SHALL handle flush:
- a flush high at a rising edge clears all stage valid bits at that edge;
- the operation offered in that cycle is not accepted;
- flush has priority over both accept and stall;
- out_valid is 0 the following cycle.
REQ-017 SHALL drive busy = OR of all stage valid bits.
REQ-018 SHALL allow simultaneous output consumption and input acceptance in the same cycle without loss.
REQ-019 SHALL keep out_result and out_tag at their last value when out_valid=0; their value there is don't-care for the consumer.

Reset
REQ-020 SHALL, while RST=1, force asynchronously: all stage valid bits 0, out_valid 0, busy 0, out_result 0, out_tag 0, all internal data registers 0.
REQ-021 SHALL drive in_ready 1 during and after reset.
REQ-022 SHALL discard any in-flight operations when reset is asserted mid-operation; no result for them appears after release.
REQ-023 SHALL be able to accept an operation on the first rising edge after RST falls.

Verification
REQ-024 SHALL cover: MUL a=7, b=6, tag=3, out_ready=1 -> out_valid exactly 6 cycles later, out_result=42, out_tag=3.
REQ-025 SHALL cover high-half modes:
- MULH a=b=0xFFFFFFFF -> result 0x00000000;
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE;
- MULHSU a=0xFFFFFFFF, b=2 -> result 0xFFFFFFFF;
- MUL a=b=0xFFFFFFFF -> result 0x00000001.
REQ-026 SHALL cover 8 back-to-back MULs (i*3, tags 0..7), out_ready=1 -> 8 consecutive out_valid cycles, in order, with correct tags.
REQ-027 SHALL cover a 3-cycle stall: out_ready=0 for 3 cycles while valid -> in_ready=0, and out_result/out_tag held; after release all results arrive in order, none lost or duplicated.
REQ-028 SHALL cover a flush with 4 in flight and in_valid=1 -> nothing accepted that cycle, out_valid=0 next cycle, busy=0, no stale results ever emerge.
REQ-029 SHALL cover RST pulsed mid-stream -> outputs 0 immediately, no pre-reset result emerges, and a post-reset MUL 5*5 yields 25 after 6 cycles; repeat the suite at WIDTH=16 (LAT=5).
